ddr3_app_responder: RTL and testbench
=====================================

Name: ddr3_app_responder

Overview:
- Synthesizable responder for the MIG 7-series user (app_*) interface. It stands in for mig_7series_0 on the ui_clk side.
- It accepts write and read commands from the frame-cache controller and stores 128-bit beats in on-chip block RAM. Read data returns in order after a fixed latency.
- Used in block-level simulation and in DDR-less bring-up builds, so the cache controller and both FIFOs can be exercised without the PHY.

Parameters:
- ADDR_W, 28, app_addr width.
- DATA_W, 128, beat width (BL8 x 16-bit).
- MEM_AW, 10, log2 of RAM depth in beats (1024 beats = 16 KiB).
- CMD_DEPTH, 4, command FIFO depth (power of 2).
- WDF_DEPTH, 8, write-data FIFO depth (power of 2).
- RD_LATENCY, 4, cycles from read execution to app_rd_data_valid (1..16).
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
- BP_PERIOD, 0, app_rdy is forced low one cycle in every BP_PERIOD cycles; 0 disables this.

Ports:
- ui_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- app_addr  in  ADDR_W  address in 16-bit units
- app_cmd  in  3  000 = write, 001 = read
- app_en  in  1  command valid
- app_rdy  out  1  command ready
- app_wdf_data  in  DATA_W  write beat
- app_wdf_mask  in  DATA_W/8  byte mask (1 = byte not written)
- app_wdf_wren  in  1  write-data valid
- app_wdf_end  in  1  last beat; must equal app_wdf_wren
- app_wdf_rdy  out  1  write-data ready
- app_rd_data  out  DATA_W  read beat
- app_rd_data_valid  out  1  read beat valid
- app_rd_data_end  out  1  equals app_rd_data_valid
- init_calib_complete  out  1  calibration-done emulation
- o_err  out  3  sticky errors: [0] misaligned address, [1] illegal command, [2] wdf_end mismatch

Behaviour:
- Reset: synchronous on i_rst_n = 0. It clears both FIFOs, the read pipeline, the calib counter, the BP counter and o_err.
  - All outputs read 0 in the cycle after the reset edge; app_rd_data reads 0.
  - RAM contents are not reset.
  - Reset mid-burst drops all queued and in-flight commands; no valid is issued for them.
- Calibration: a counter runs from reset release. init_calib_complete rises CALIB_CYCLES edges later and stays high until the next reset.
- app_rdy = calib && !cmd_full && !bp_stall. Command handshake = app_en && app_rdy.
  - app_rdy does not depend combinationally on app_en.
  - bp_stall is asserted in one cycle of every BP_PERIOD, counted from calib rise.
- app_wdf_rdy = calib && !wdf_full. Data handshake = app_wdf_wren && app_wdf_rdy.
  - Data may arrive before, with, or after its command; pairing is strictly by order.
- Beat index = app_addr[MEM_AW+2:3]. Higher bits are ignored, so addresses wrap modulo 2^MEM_AW beats.
  - app_addr[2:0] != 0: the command is still executed with those bits ignored, and o_err[0] is set.
- Illegal app_cmd (not 000/001): the command is accepted, dropped at execution, and o_err[1] is set.
- A beat accepted with app_wdf_end != app_wdf_wren sets o_err[2].
- Executor: one command per cycle, taken from the command FIFO head, strictly in order.
  - Write at head, WDF nonempty: in the same cycle, pop both FIFOs and write the RAM with the byte mask applied.
  - Write at head, WDF empty: stall; all later commands wait.
  - Read at head: pop, read the RAM, and push into a RD_LATENCY-deep valid/data shift pipeline.
  - A read always observes every earlier-queued write, because writes execute in order ahead of it.
- Latency: with both FIFOs empty, a read accepted at edge N drives app_rd_data_valid high for exactly one cycle, starting at edge N+1+RD_LATENCY.
  - A write accepted at edge N, with its data already queued, updates the RAM at edge N+1.
- Back-to-back reads give one valid per cycle with no bubbles.
- Simultaneous command push and executor pop in the same cycle keeps the FIFO count unchanged and does not deassert app_rdy.
- Full FIFO: app_rdy or app_wdf_rdy is low; an asserted app_en or app_wdf_wren is simply not accepted, with no error.
- Before calibration: both ready signals are low and nothing is accepted.

Test Plan:
1. Reset, then count cycles. Required: init_calib_complete rises exactly 64 edges after reset release; app_rdy and app_wdf_rdy stay 0 before that.
2. Write beat 128'h0123...CDEF at addr 0x40, then read addr 0x40 with the queue empty. Required: valid at read edge + 5, data 128'h0123...CDEF, app_rd_data_end = 1.
3. Issue 80 write commands, addr 0, 8, ..., 632, with data offered 3 cycles late. Then issue 80 reads.
   - Required: 80 valids in order with matching data.
   - Required: app_rdy drops while 4 commands are queued.
   - Required: app_wdf_rdy drops while 8 beats are queued.
4. Write all-ones to addr 0, then write 0 with mask 16'hFF00. Required: read returns 128'hFFFF...FFFF_0000...0000 (upper 8 bytes unchanged).
5. Error flags:
   - Address 0x41 → o_err = 3'b001.
   - Then app_cmd = 3'b010 → o_err = 3'b011.
   - Reset → o_err = 0.
6. BP_PERIOD = 5, stream 20 reads. Then assert reset while 3 reads are in flight.
   - Required: app_rdy low every 5th cycle; all 20 reads complete in order.
   - Required: after the reset edge, no further valids appear.

Source files
------------

// File: rtl/ddr3_app_responder.sv
// MIG 7-series app_* interface responder backed by on-chip block RAM.
// Commands and write beats pair strictly in order; reads return after a fixed latency.
module ddr3_app_responder #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int MEM_AW       = 10,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 8,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int BP_PERIOD    = 0
) (
    input  logic                ui_clk,
    input  logic                i_rst_n,
    input  logic [ADDR_W-1:0]   app_addr,
    input  logic [2:0]          app_cmd,
    input  logic                app_en,
    output logic                app_rdy,
    input  logic [DATA_W-1:0]   app_wdf_data,
    input  logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_wren,
    input  logic                app_wdf_end,
    output logic                app_wdf_rdy,
    output logic [DATA_W-1:0]   app_rd_data,
    output logic                app_rd_data_valid,
    output logic                app_rd_data_end,
    output logic                init_calib_complete,
    output logic [2:0]          o_err
);

    localparam int BW  = DATA_W / 8;
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int WAW = $clog2(WDF_DEPTH);
    localparam int CCW = $clog2(CALIB_CYCLES + 1);
    localparam int BPW = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;

    typedef enum logic [1:0] {
        K_WR  = 2'd0,
        K_RD  = 2'd1,
        K_ILL = 2'd2
    } kind_t;

    logic           calib;
    logic [CCW-1:0] cal_cnt;
    logic [BPW-1:0] bp_cnt;
    logic           bp_stall;

    always_ff @(posedge ui_clk) begin
        if (!i_rst_n) begin
            calib   <= 1'b0;
            cal_cnt <= '0;
        end else if (!calib) begin
            if (cal_cnt == CCW'(CALIB_CYCLES - 1))
                calib <= 1'b1;
            else
                cal_cnt <= cal_cnt + 1'b1;
        end
    end

    // Back-pressure phase is counted from the calibration-done edge.
    always_ff @(posedge ui_clk) begin
        if (!i_rst_n)
            bp_cnt <= '0;
        else if (calib && BP_PERIOD != 0)
            bp_cnt <= (bp_cnt == BPW'(BP_PERIOD - 1)) ? '0 : bp_cnt + 1'b1;
    end

    assign bp_stall = (BP_PERIOD != 0) && calib
                   && (bp_cnt == BPW'(BP_PERIOD - 1));

    logic [CAW:0]       c_wp, c_rp, c_cnt;
    kind_t              c_kind [CMD_DEPTH];
    logic [MEM_AW-1:0]  c_idx  [CMD_DEPTH];
    logic               cmd_full, cmd_empty, cmd_push, cmd_pop;
    kind_t              kind_in;

    logic [WAW:0]       w_wp, w_rp, w_cnt;
    logic [DATA_W-1:0]  w_data [WDF_DEPTH];
    logic [BW-1:0]      w_mask [WDF_DEPTH];
    logic               wdf_full, wdf_empty, wdf_push;

    assign c_cnt     = c_wp - c_rp;
    assign cmd_full  = (c_cnt == (CAW+1)'(CMD_DEPTH));
    assign cmd_empty = (c_wp == c_rp);
    assign w_cnt     = w_wp - w_rp;
    assign wdf_full  = (w_cnt == (WAW+1)'(WDF_DEPTH));
    assign wdf_empty = (w_wp == w_rp);

    assign app_rdy     = calib && !cmd_full && !bp_stall;
    assign app_wdf_rdy = calib && !wdf_full;
    assign cmd_push    = app_en && app_rdy;
    assign wdf_push    = app_wdf_wren && app_wdf_rdy;

    always_comb begin
        kind_in = K_ILL;
        if (app_cmd == 3'b000)
            kind_in = K_WR;
        else if (app_cmd == 3'b001)
            kind_in = K_RD;
    end

    always_ff @(posedge ui_clk) begin
        if (cmd_push) begin
            c_kind[c_wp[CAW-1:0]] <= kind_in;
            c_idx[c_wp[CAW-1:0]]  <= app_addr[MEM_AW+2:3];
        end
        if (wdf_push) begin
            w_data[w_wp[WAW-1:0]] <= app_wdf_data;
            w_mask[w_wp[WAW-1:0]] <= app_wdf_mask;
        end
    end

    kind_t             h_kind;
    logic [MEM_AW-1:0] h_idx;
    logic [DATA_W-1:0] h_data;
    logic [BW-1:0]     h_mask;
    logic              ex_wr, ex_rd, ex_drop;

    assign h_kind = c_kind[c_rp[CAW-1:0]];
    assign h_idx  = c_idx[c_rp[CAW-1:0]];
    assign h_data = w_data[w_rp[WAW-1:0]];
    assign h_mask = w_mask[w_rp[WAW-1:0]];

    // A write at the head with no data yet blocks every later command.
    always_comb begin
        ex_wr   = 1'b0;
        ex_rd   = 1'b0;
        ex_drop = 1'b0;
        if (i_rst_n && !cmd_empty) begin
            unique case (h_kind)
                K_WR:    ex_wr   = !wdf_empty;
                K_RD:    ex_rd   = 1'b1;
                default: ex_drop = 1'b1;
            endcase
        end
    end

    assign cmd_pop = ex_wr || ex_rd || ex_drop;

    always_ff @(posedge ui_clk) begin
        if (!i_rst_n) begin
            c_wp <= '0;
            c_rp <= '0;
            w_wp <= '0;
            w_rp <= '0;
        end else begin
            c_wp <= c_wp + (CAW+1)'(cmd_push);
            c_rp <= c_rp + (CAW+1)'(cmd_pop);
            w_wp <= w_wp + (WAW+1)'(wdf_push);
            w_rp <= w_rp + (WAW+1)'(ex_wr);
        end
    end

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
    logic [DATA_W-1:0] ram_q;

    always_ff @(posedge ui_clk) begin
        if (ex_wr) begin
            for (int b = 0; b < BW; b++)
                if (!h_mask[b])
                    mem[h_idx][b*8 +: 8] <= h_data[b*8 +: 8];
        end
        if (ex_rd)
            ram_q <= mem[h_idx];
    end

    logic                  ram_v;
    logic [RD_LATENCY-1:0] pv;
    logic [DATA_W-1:0]     pd [RD_LATENCY];

    always_ff @(posedge ui_clk) begin
        if (!i_rst_n) begin
            ram_v <= 1'b0;
            pv    <= '0;
            for (int i = 0; i < RD_LATENCY; i++)
                pd[i] <= '0;
        end else begin
            ram_v <= ex_rd;
            pv[0] <= ram_v;
            pd[0] <= ram_v ? ram_q : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign app_rd_data         = pd[RD_LATENCY-1];
    assign app_rd_data_valid   = pv[RD_LATENCY-1];
    assign app_rd_data_end     = pv[RD_LATENCY-1];
    assign init_calib_complete = calib;

    always_ff @(posedge ui_clk) begin
        if (!i_rst_n) begin
            o_err <= '0;
        end else begin
            if (cmd_push && app_addr[2:0] != 3'b000)
                o_err[0] <= 1'b1;
            if (cmd_push && app_cmd[2:1] != 2'b00)
                o_err[1] <= 1'b1;
            if (wdf_push && !app_wdf_end)
                o_err[2] <= 1'b1;
        end
    end

    logic unused_addr;
    assign unused_addr = ^app_addr[ADDR_W-1:MEM_AW+3];

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder.
// Back-pressure is enabled at period 5 throughout.
module tb_ddr3_app_responder;

    logic         ui_clk;
    logic         i_rst_n;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
    logic [2:0]   o_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int calib_cyc = 0;

    logic [127:0] rd_q[$];
    int           rd_t[$];
    logic         rd_e[$];
    logic [27:0]  ra_q[$];
    logic [127:0] ex_q[$];

    ddr3_app_responder #(.BP_PERIOD(5)) dut (
        .ui_clk              (ui_clk),
        .i_rst_n             (i_rst_n),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .o_err               (o_err)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    always @(posedge ui_clk) cyc <= cyc + 1;

    always @(negedge ui_clk) begin
        if (app_rd_data_valid === 1'b1) begin
            rd_q.push_back(app_rd_data);
            rd_t.push_back(cyc);
            rd_e.push_back(app_rd_data_end);
        end
    end

    function automatic logic [127:0] pat(input int i);
        return {32'(i) ^ 32'hA5A50000, ~32'(i),
                32'(i * 7 + 3), 32'hC0DE0000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic clear_rd();
        rd_q.delete();
        rd_t.delete();
        rd_e.delete();
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [27:0] a,
                            output int acc);
        bit got;
        got = 0;
        acc = -1;
        app_cmd = c;
        app_addr = a;
        app_en = 1'b1;
        for (int w = 0; w < 200; w++) begin
            if (app_rdy === 1'b1) begin
                tick();
                acc = cyc;
                got = 1;
                break;
            end
            tick();
        end
        app_en = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL cmd_accept: addr=%h not accepted in 200 cycles",
                     a);
        end
    endtask

    task automatic send_data(input logic [127:0] d, input logic [15:0] m,
                             input logic e);
        bit got;
        got = 0;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_end = e;
        app_wdf_wren = 1'b1;
        for (int w = 0; w < 200; w++) begin
            if (app_wdf_rdy === 1'b1) begin
                tick();
                got = 1;
                break;
            end
            tick();
        end
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL data_accept: beat not accepted in 200 cycles");
        end
    endtask

    task automatic do_reset(output int k);
        int bad;
        app_en = 1'b0;
        app_wdf_wren = 1'b0;
        i_rst_n = 1'b0;
        tick();
        checks++;
        if ({init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid,
             app_rd_data_end, o_err} !== 8'd0 || app_rd_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: calib=%b rdy=%b wrdy=%b v=%b e=%b err=%b d=%h want all 0",
                     init_calib_complete, app_rdy, app_wdf_rdy,
                     app_rd_data_valid, app_rd_data_end, o_err, app_rd_data);
        end
        tick();
        i_rst_n = 1'b1;
        k = 0;
        bad = 0;
        while (init_calib_complete !== 1'b1 && k < 300) begin
            tick();
            k++;
            if (init_calib_complete !== 1'b1
                && (app_rdy !== 1'b0 || app_wdf_rdy !== 1'b0))
                bad++;
        end
        calib_cyc = cyc;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rdy_before_calib: %0d cycles with ready high, want 0",
                     bad);
        end
    endtask

    task automatic run_reads(input string nm);
        int acc, n, bad, w;
        clear_rd();
        n = ra_q.size();
        foreach (ra_q[i]) send_cmd(3'b001, ra_q[i], acc);
        w = 0;
        while (rd_q.size() < n && w < 300) begin
            tick();
            w++;
        end
        repeat (8) tick();
        checks++;
        if (rd_q.size() != n) begin
            failures++;
            $display("FAIL %s_count: got %0d valids, want %0d",
                     nm, rd_q.size(), n);
        end
        bad = 0;
        for (int i = 0; i < n && i < rd_q.size(); i++)
            if (rd_q[i] !== ex_q[i] || rd_e[i] !== 1'b1)
                bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_data: %0d beats wrong, want 0 (first got %h want %h)",
                     nm, bad, rd_q[0], ex_q[0]);
        end
        ra_q.delete();
        ex_q.delete();
    endtask

    task automatic test_reset();
        int k;
        do_reset(k);
        checks++;
        if (k != 64) begin
            failures++;
            $display("FAIL calib_edges: got %0d, want 64", k);
        end
        checks++;
        if (app_rdy !== 1'b1 || app_wdf_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rdy_after_calib: rdy=%b wrdy=%b, want 1 1",
                     app_rdy, app_wdf_rdy);
        end
    endtask

    task automatic test_write_read();
        logic [127:0] d;
        int acc;
        d = 128'h0123456789ABCDEF0123456789ABCDEF;
        send_data(d, 16'h0, 1'b1);
        send_cmd(3'b000, 28'h40, acc);
        repeat (3) tick();
        clear_rd();
        send_cmd(3'b001, 28'h40, acc);
        repeat (10) tick();
        checks++;
        if (rd_q.size() != 1) begin
            failures++;
            $display("FAIL wr_rd_count: got %0d valids, want 1", rd_q.size());
        end else begin
            checks++;
            if (rd_t[0] != acc + 5) begin
                failures++;
                $display("FAIL rd_latency: valid at edge %0d, want %0d",
                         rd_t[0], acc + 5);
            end
            checks++;
            if (rd_q[0] !== d || rd_e[0] !== 1'b1) begin
                failures++;
                $display("FAIL wr_rd_data: got %h end=%b, want %h end=1",
                         rd_q[0], rd_e[0], d);
            end
        end
    endtask

    task automatic test_fill();
        int acc, hi;
        for (int i = 0; i < 4; i++)
            send_cmd(3'b000, 28'((100 + i) * 8), acc);
        app_cmd = 3'b000;
        app_addr = 28'(104 * 8);
        app_en = 1'b1;
        hi = 0;
        repeat (8) begin
            tick();
            if (app_rdy !== 1'b0) hi++;
        end
        app_en = 1'b0;
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL cmd_full: app_rdy high %0d cycles, want 0", hi);
        end
        for (int i = 0; i < 4; i++)
            send_data(pat(1000 + i), 16'h0, 1'b1);
        for (int i = 0; i < 8; i++)
            send_data(pat(2000 + i), 16'h0, 1'b1);
        app_wdf_data = pat(9999);
        app_wdf_mask = 16'h0;
        app_wdf_end = 1'b1;
        app_wdf_wren = 1'b1;
        hi = 0;
        repeat (6) begin
            tick();
            if (app_wdf_rdy !== 1'b0) hi++;
        end
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL wdf_full: app_wdf_rdy high %0d cycles, want 0", hi);
        end
        for (int i = 0; i < 8; i++)
            send_cmd(3'b000, 28'((200 + i) * 8), acc);
        fork
            begin
                int a2;
                for (int i = 0; i < 80; i++)
                    send_cmd(3'b000, 28'(i * 8), a2);
            end
            begin
                repeat (3) tick();
                for (int i = 0; i < 80; i++)
                    send_data(pat(i), 16'h0, 1'b1);
            end
        join
        for (int i = 0; i < 4; i++) begin
            ra_q.push_back(28'((100 + i) * 8));
            ex_q.push_back(pat(1000 + i));
        end
        for (int i = 0; i < 8; i++) begin
            ra_q.push_back(28'((200 + i) * 8));
            ex_q.push_back(pat(2000 + i));
        end
        for (int i = 0; i < 80; i++) begin
            ra_q.push_back(28'(i * 8));
            ex_q.push_back(pat(i));
        end
        run_reads("fill");
    endtask

    task automatic test_mask();
        int acc;
        send_data('1, 16'h0, 1'b1);
        send_cmd(3'b000, 28'h0, acc);
        send_data('0, 16'hFF00, 1'b1);
        send_cmd(3'b000, 28'h0, acc);
        ra_q.push_back(28'h0);
        ex_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        run_reads("mask");
    endtask

    task automatic test_errors();
        int acc, k;
        checks++;
        if (o_err !== 3'b000) begin
            failures++;
            $display("FAIL err_clean: got %b, want 000", o_err);
        end
        clear_rd();
        send_cmd(3'b001, 28'h41, acc);
        repeat (3) tick();
        checks++;
        if (o_err !== 3'b001) begin
            failures++;
            $display("FAIL err_misalign: got %b, want 001", o_err);
        end
        send_cmd(3'b010, 28'h0, acc);
        send_cmd(3'b001, 28'((1024 + 9) * 8), acc);
        repeat (3) tick();
        checks++;
        if (o_err !== 3'b011) begin
            failures++;
            $display("FAIL err_illegal: got %b, want 011", o_err);
        end
        send_data(pat(7777), 16'h0, 1'b0);
        repeat (2) tick();
        checks++;
        if (o_err !== 3'b111) begin
            failures++;
            $display("FAIL err_wdf_end: got %b, want 111", o_err);
        end
        repeat (8) tick();
        checks++;
        if (rd_q.size() != 2 || rd_q[0] !== pat(8) || rd_q[1] !== pat(9)) begin
            failures++;
            $display("FAIL err_reads: got %0d beats first %h, want 2 beats %h %h",
                     rd_q.size(), rd_q.size() > 0 ? rd_q[0] : '0,
                     pat(8), pat(9));
        end
        do_reset(k);
        checks++;
        if (o_err !== 3'b000) begin
            failures++;
            $display("FAIL err_reset: got %b, want 000", o_err);
        end
    endtask

    task automatic test_back_to_back();
        int sent, bad, lows, w, acc, n;
        logic exp_rdy, was_rdy;
        clear_rd();
        sent = 0;
        bad = 0;
        lows = 0;
        w = 0;
        app_cmd = 3'b001;
        while (sent < 20 && w < 200) begin
            app_addr = 28'((20 + sent) * 8);
            app_en = 1'b1;
            exp_rdy = ((cyc - calib_cyc) % 5) != 4;
            if (app_rdy !== exp_rdy) bad++;
            if (!exp_rdy) lows++;
            was_rdy = app_rdy;
            tick();
            w++;
            if (was_rdy === 1'b1) sent++;
        end
        app_en = 1'b0;
        checks++;
        if (bad != 0 || sent != 20 || lows < 3) begin
            failures++;
            $display("FAIL bp_pattern: %0d rdy errors, %0d sent, %0d stalls, want 0 20 >=3",
                     bad, sent, lows);
        end
        repeat (12) tick();
        n = 0;
        for (int i = 0; i < rd_q.size() && i < 20; i++)
            if (rd_q[i] !== pat(20 + i)) n++;
        checks++;
        if (rd_q.size() != 20 || n != 0) begin
            failures++;
            $display("FAIL bp_reads: got %0d beats %0d wrong, want 20 0",
                     rd_q.size(), n);
        end
        clear_rd();
        for (int i = 0; i < 3; i++)
            send_cmd(3'b001, 28'((40 + i) * 8), acc);
        i_rst_n = 1'b0;
        tick();
        checks++;
        if (app_rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid: got %b, want 0", app_rd_data_valid);
        end
        tick();
        i_rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL rst_flush: got %0d valids, want 0", rd_q.size());
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        app_addr = '0;
        app_cmd = '0;
        app_en = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
        repeat (2) @(posedge ui_clk);
        #1;
        test_reset();
        test_write_read();
        test_fill();
        test_mask();
        test_errors();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
